// File: rtl/pe_dot_mac.sv
// pe_dot_mac: handshaked signed fixed-point dot-product engine.
// It accumulates (a*b)>>>FRAC_W over one vector into a saturating ACC_W accumulator.
// At the end of the vector it produces a DATA_W result, with optional ReLU6.
module pe_dot_mac #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned RELU_CAP = 6
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] bias,
    input  logic              cfg_bias_en,
    input  logic              cfg_relu,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] r,
    output logic [ACC_W-1:0]  acc_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              ovf_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    localparam int R_MAX_I = (2 ** (DATA_W - 1)) - 1;
    localparam int R_MIN_I = -(2 ** (DATA_W - 1));
    localparam int CAP_RAW = int'(RELU_CAP) * (2 ** FRAC_W);
    localparam int CAP_I   = (CAP_RAW < R_MAX_I) ? CAP_RAW : R_MAX_I;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] R_MAX_A = ACC_W'(R_MAX_I);
    localparam logic signed [ACC_W-1:0] R_MIN_A = ACC_W'(R_MIN_I);
    localparam logic [DATA_W-1:0]       R_MAX_D = DATA_W'(R_MAX_I);
    localparam logic [DATA_W-1:0]       R_MIN_D = DATA_W'(R_MIN_I);
    localparam logic [DATA_W-1:0]       CAP_D   = DATA_W'(CAP_I);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                    state_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      ovf_q;
    logic                      relu_q;

    logic signed [PROD_W-1:0]  prod;
    logic signed [PROD_W-1:0]  p_sh;
    logic signed [ACC_W-1:0]   p_ext;
    logic signed [ACC_W-1:0]   add_base;
    logic [ACC_W:0]            sum;
    logic                      add_ovf;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic [CNT_W-1:0]          cnt_nxt;
    logic                      ovf_nxt;
    logic                      relu_sel;
    logic [DATA_W-1:0]         s_clamp;
    logic [DATA_W-1:0]         r_nxt;
    logic                      beat;

    // Datapath for the beat presented this cycle: product, saturating add, result shaping
    always_comb begin
        prod     = $signed(a) * $signed(b);
        p_sh     = prod >>> FRAC_W;
        p_ext    = ACC_W'(p_sh);
        add_base = acc_q;
        if (state_q == IDLE) begin
            add_base = cfg_bias_en ? ACC_W'($signed(bias)) : '0;
        end
        sum      = {add_base[ACC_W-1], add_base} + {p_ext[ACC_W-1], p_ext};
        add_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
        acc_nxt  = add_ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : $signed(sum[ACC_W-1:0]);

        cnt_nxt  = CNT_W'(1);
        ovf_nxt  = add_ovf;
        relu_sel = cfg_relu;
        if (state_q != IDLE) begin
            cnt_nxt  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            ovf_nxt  = ovf_q | add_ovf;
            relu_sel = relu_q;
        end

        if (acc_nxt > R_MAX_A) begin
            s_clamp = R_MAX_D;
        end else if (acc_nxt < R_MIN_A) begin
            s_clamp = R_MIN_D;
        end else begin
            s_clamp = acc_nxt[DATA_W-1:0];
        end

        r_nxt = s_clamp;
        if (relu_sel) begin
            if (s_clamp[DATA_W-1]) begin
                r_nxt = '0;
            end else if (s_clamp > CAP_D) begin
                r_nxt = CAP_D;
            end
        end

        beat = in_valid && in_ready;
    end

    // Sequencer: collect beats, register the result on entry to OUT, hold it until taken
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            relu_q    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            r         <= '0;
            acc_o     <= '0;
            count_o   <= '0;
            ovf_o     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat) begin
                        acc_q  <= acc_nxt;
                        cnt_q  <= cnt_nxt;
                        ovf_q  <= ovf_nxt;
                        relu_q <= relu_sel;
                        if (in_last) begin
                            state_q   <= OUT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            r         <= r_nxt;
                            acc_o     <= acc_nxt;
                            count_o   <= cnt_nxt;
                            ovf_o     <= ovf_nxt;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_dot_mac.sv
// Testbench for pe_dot_mac: directed vectors plus an integer-level reference model.
module tb_pe_dot_mac;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned FRAC_W   = 4;
    localparam int unsigned ACC_W    = 16;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned RELU_CAP = 6;

    logic              clk = 1'b0;
    logic              n_reset;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] bias;
    logic              cfg_bias_en;
    logic              cfg_relu;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] r;
    logic [ACC_W-1:0]  acc_o;
    logic [CNT_W-1:0]  count_o;
    logic              ovf_o;

    int errors = 0;
    int checks = 0;

    pe_dot_mac #(
        .DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .RELU_CAP(RELU_CAP)
    ) dut (
        .clk(clk), .n_reset(n_reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a(a), .b(b), .bias(bias), .cfg_bias_en(cfg_bias_en), .cfg_relu(cfg_relu),
        .out_valid(out_valid), .out_ready(out_ready),
        .r(r), .acc_o(acc_o), .count_o(count_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-vector integer arithmetic, advanced at each rising edge
    bit              m_live = 1'b0;
    bit              m_pend = 1'b0;
    bit              m_busy = 1'b0;
    bit              m_relu = 1'b0;
    bit              m_ovf  = 1'b0;
    int              m_acc  = 0;
    int              m_cnt  = 0;
    int              m_p;
    int              m_s;
    logic [DATA_W-1:0] e_r   = '0;
    logic [ACC_W-1:0]  e_acc = '0;
    logic [CNT_W-1:0]  e_cnt = '0;
    logic              e_ovf = 1'b0;

    always @(posedge clk) begin
        m_live = 1'b1;
        if (!n_reset) begin
            m_pend = 0; m_busy = 0; m_relu = 0; m_ovf = 0; m_acc = 0; m_cnt = 0;
            e_r = '0; e_acc = '0; e_cnt = '0; e_ovf = 1'b0;
        end else if (m_pend) begin
            if (out_ready) m_pend = 0;
        end else if (in_valid) begin
            if (!m_busy) begin
                m_acc  = cfg_bias_en ? int'($signed(bias)) : 0;
                m_cnt  = 0;
                m_ovf  = 0;
                m_relu = cfg_relu;
            end
            m_p   = (int'($signed(a)) * int'($signed(b))) >>> FRAC_W;
            m_acc = m_acc + m_p;
            if (m_acc > 32767) begin
                m_acc = 32767; m_ovf = 1;
            end else if (m_acc < -32768) begin
                m_acc = -32768; m_ovf = 1;
            end
            if (m_cnt < 255) m_cnt = m_cnt + 1;
            if (in_last) begin
                m_s = m_acc;
                if (m_s > 127)  m_s = 127;
                if (m_s < -128) m_s = -128;
                if (m_relu) begin
                    if (m_s < 0) m_s = 0;
                    else if (m_s > int'(RELU_CAP) * 16) m_s = int'(RELU_CAP) * 16;
                end
                e_r    = 8'(m_s);
                e_acc  = 16'(m_acc);
                e_cnt  = 8'(m_cnt);
                e_ovf  = m_ovf;
                m_pend = 1;
                m_busy = 0;
            end else begin
                m_busy = 1;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc.out_valid", 32'(out_valid), 32'(m_pend));
            chk("cyc.in_ready", 32'(in_ready), 32'(!m_pend));
            chk("cyc.r", 32'(r), 32'(e_r));
            chk("cyc.acc_o", 32'(acc_o), 32'(e_acc));
            chk("cyc.count_o", 32'(count_o), 32'(e_cnt));
            chk("cyc.ovf_o", 32'(ovf_o), 32'(e_ovf));
        end
    end

    task automatic cfg(input logic [7:0] tbias, input logic ten, input logic trelu);
        bias = tbias; cfg_bias_en = ten; cfg_relu = trelu;
    endtask

    // One beat, starting just after a rising edge; later cfg/bias values are scrambled
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tl);
        in_valid = 1'b1; a = ta; b = tb; in_last = tl;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); in_last = 1'($urandom);
        bias = 8'($urandom); cfg_bias_en = 1'($urandom); cfg_relu = 1'($urandom);
    endtask

    // Result must appear one cycle after the last beat; then it is consumed if out_ready=1
    task automatic expect_result(input string tag, input logic [7:0] er, input logic [15:0] ea,
                                 input logic [7:0] ec, input logic eo);
        @(negedge clk);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".r"}, 32'(r), 32'(er));
        chk({tag, ".acc_o"}, 32'(acc_o), 32'(ea));
        chk({tag, ".count_o"}, 32'(count_o), 32'(ec));
        chk({tag, ".ovf_o"}, 32'(ovf_o), 32'(eo));
        @(posedge clk); #1;
    endtask

    initial begin
        n_reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0;
        bias = '0; cfg_bias_en = 1'b0; cfg_relu = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.r", 32'(r), 32'd0);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        n_reset = 1'b1;
        @(posedge clk); #1;

        // single beat with bias
        cfg(8'h10, 1'b1, 1'b0);
        send(8'h10, 8'h10, 1'b1);
        expect_result("bias1", 8'h20, 16'h0020, 8'd1, 1'b0);

        // three-beat vector
        cfg(8'h00, 1'b0, 1'b0);
        send(8'h10, 8'h20, 1'b0);
        send(8'h18, 8'h10, 1'b0);
        send(8'hF8, 8'h10, 1'b1);
        expect_result("three", 8'h30, 16'h0030, 8'd3, 1'b0);

        // ReLU6 cap and negative clip
        cfg(8'h00, 1'b0, 1'b1);
        send(8'h40, 8'h20, 1'b1);
        expect_result("relu_cap", 8'h60, 16'h0080, 8'd1, 1'b0);
        cfg(8'h00, 1'b0, 1'b1);
        send(8'hE0, 8'h10, 1'b1);
        expect_result("relu_neg", 8'h00, 16'hFFE0, 8'd1, 1'b0);

        // accumulator saturation, then sticky overflow cleared by next vector
        cfg(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) send(8'h7F, 8'h7F, (i == 39));
        expect_result("sat", 8'h7F, 16'h7FFF, 8'd40, 1'b1);
        cfg(8'h00, 1'b0, 1'b0);
        send(8'h10, 8'h10, 1'b1);
        expect_result("after_sat", 8'h10, 16'h0010, 8'd1, 1'b0);

        // backpressure: result held, offered beats refused
        out_ready = 1'b0;
        cfg(8'h00, 1'b0, 1'b0);
        send(8'h20, 8'h20, 1'b1);
        in_valid = 1'b1; a = 8'h10; b = 8'h10; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.out_valid", 32'(out_valid), 32'd1);
            chk("bp.r", 32'(r), 32'h40);
            chk("bp.in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release.out_valid", 32'(out_valid), 32'd0);
        chk("bp_release.in_ready", 32'(in_ready), 32'd1);
        chk("bp_release.r_hold", 32'(r), 32'h40);
        cfg(8'h00, 1'b0, 1'b0);
        send(8'h10, 8'h10, 1'b1);
        expect_result("after_bp", 8'h10, 16'h0010, 8'd1, 1'b0);

        // reset in the middle of a vector
        cfg(8'h30, 1'b1, 1'b0);
        send(8'h10, 8'h10, 1'b0);
        send(8'h20, 8'h20, 1'b0);
        n_reset = 1'b0;
        @(posedge clk); #1;
        chk("midrst.r", 32'(r), 32'd0);
        chk("midrst.acc_o", 32'(acc_o), 32'd0);
        chk("midrst.count_o", 32'(count_o), 32'd0);
        chk("midrst.ovf_o", 32'(ovf_o), 32'd0);
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        n_reset = 1'b1;
        cfg(8'h00, 1'b0, 1'b0);
        send(8'h10, 8'h10, 1'b1);
        expect_result("post_rst", 8'h10, 16'h0010, 8'd1, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
